// File: rtl/symbol_packer.sv
// symbol_packer
// Collects SYM_W-bit symbols into words of PQ_SYMBOLS symbols for the
// word-wide egress FIFO. Supports partial-word flush with padding, a single
// output register with backpressure, and a registered drop pulse for symbols
// offered while the packer cannot take them.
module symbol_packer #(
    parameter int               PQ_SYMBOLS = 4,
    parameter int               SYM_W      = 4,
    parameter bit               MSB_FIRST  = 1'b0,
    parameter logic [SYM_W-1:0] PAD_VAL    = '0,
    localparam int              NS_W       = $clog2(PQ_SYMBOLS + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic [SYM_W-1:0]            i_sym,
    output logic                        o_rdy,
    input  logic                        i_flush,
    output logic                        o_flush_ack,
    output logic [PQ_SYMBOLS*SYM_W-1:0] o_all_symbols,
    output logic [NS_W-1:0]             o_nsym,
    output logic                        o_valid,
    input  logic                        i_out_rdy,
    output logic                        o_drop
);

    localparam int                WORD_W   = PQ_SYMBOLS * SYM_W;
    localparam logic [NS_W-1:0]   LAST_CNT = NS_W'(PQ_SYMBOLS - 1);
    localparam logic [WORD_W-1:0] PAD_WORD = {PQ_SYMBOLS{PAD_VAL}};

    // fill counter, 0..PQ_SYMBOLS-1
    logic [NS_W-1:0]   cnt;
    // accumulator; slots not yet written always hold PAD_VAL
    logic [WORD_W-1:0] acc;

    logic              slot_free;
    logic              accept;
    logic              flush_take;
    logic              word_full;
    logic              emit;
    logic [NS_W-1:0]   fill;
    logic [NS_W-1:0]   wr_slot;
    logic [WORD_W-1:0] merged;

    // The output register can take a new word when it is empty or draining.
    assign slot_free   = !o_valid || i_out_rdy;

    // Only the symbol that completes a word needs room in the output register.
    assign o_rdy       = (cnt != LAST_CNT) || slot_free;
    assign accept      = i_en && o_rdy;

    assign flush_take  = i_flush && slot_free;
    assign o_flush_ack = flush_take;

    // Fill level including a symbol accepted this cycle.
    assign fill        = cnt + NS_W'(accept);
    assign word_full   = accept && (cnt == LAST_CNT);

    // A flush on an empty accumulator is acknowledged without producing a word.
    assign emit        = word_full || (flush_take && (fill != '0));

    assign wr_slot     = MSB_FIRST ? (LAST_CNT - cnt) : cnt;

    // Accumulator contents with this cycle's symbol written into its slot.
    always_comb begin
        merged = acc;
        if (accept) begin
            merged[int'(wr_slot)*SYM_W +: SYM_W] = i_sym;
        end
    end

    // Fill counter and accumulator; restart with pad slots after every emitted word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
            acc <= PAD_WORD;
        end else if (emit) begin
            cnt <= '0;
            acc <= PAD_WORD;
        end else if (accept) begin
            cnt <= cnt + NS_W'(1);
            acc <= merged;
        end
    end

    // Output register: load on emit (also covers back-to-back), clear valid on drain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_all_symbols <= '0;
            o_nsym        <= '0;
            o_valid       <= 1'b0;
        end else if (emit) begin
            o_all_symbols <= merged;
            o_nsym        <= fill;
            o_valid       <= 1'b1;
        end else if (o_valid && i_out_rdy) begin
            o_valid       <= 1'b0;
        end
    end

    // Drop pulse for a symbol offered while the packer was stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_drop <= 1'b0;
        end else begin
            o_drop <= i_en && !o_rdy;
        end
    end

endmodule

// File: tb/tb_symbol_packer.sv
// Bench for symbol_packer: three instances (LSB-first with pad F, MSB-first,
// and a 5x3-bit variant), a symbol-list reference model checked every cycle,
// and directed literal expectations.
module tb_symbol_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en_v    [3];
    logic flush_v [3];
    logic ordy_v  [3];
    logic [3:0] sym_a, sym_b;
    logic [2:0] sym_c;

    logic        rdy_a, ack_a, valid_a, drop_a;
    logic [15:0] word_a;
    logic [2:0]  nsym_a;
    logic        rdy_b, ack_b, valid_b, drop_b;
    logic [15:0] word_b;
    logic [2:0]  nsym_b;
    logic        rdy_c, ack_c, valid_c, drop_c;
    logic [14:0] word_c;
    logic [2:0]  nsym_c;

    int checks = 0;
    int errors = 0;

    symbol_packer #(.PQ_SYMBOLS(4), .SYM_W(4), .MSB_FIRST(1'b0), .PAD_VAL(4'hF)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en_v[0]), .i_sym(sym_a), .o_rdy(rdy_a),
        .i_flush(flush_v[0]), .o_flush_ack(ack_a), .o_all_symbols(word_a),
        .o_nsym(nsym_a), .o_valid(valid_a), .i_out_rdy(ordy_v[0]), .o_drop(drop_a)
    );

    symbol_packer #(.PQ_SYMBOLS(4), .SYM_W(4), .MSB_FIRST(1'b1), .PAD_VAL(4'h0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en_v[1]), .i_sym(sym_b), .o_rdy(rdy_b),
        .i_flush(flush_v[1]), .o_flush_ack(ack_b), .o_all_symbols(word_b),
        .o_nsym(nsym_b), .o_valid(valid_b), .i_out_rdy(ordy_v[1]), .o_drop(drop_b)
    );

    symbol_packer #(.PQ_SYMBOLS(5), .SYM_W(3), .MSB_FIRST(1'b0), .PAD_VAL(3'h5)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_en(en_v[2]), .i_sym(sym_c), .o_rdy(rdy_c),
        .i_flush(flush_v[2]), .o_flush_ack(ack_c), .o_all_symbols(word_c),
        .o_nsym(nsym_c), .o_valid(valid_c), .i_out_rdy(ordy_v[2]), .o_drop(drop_c)
    );

    function automatic int pq_of(input int i);
        return (i == 2) ? 5 : 4;
    endfunction

    function automatic int sw_of(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 1);
    endfunction

    function automatic int pad_of(input int i);
        return (i == 0) ? 'hF : ((i == 2) ? 5 : 0);
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Reference model: list of symbols gathered so far plus the word (if any)
    // waiting downstream.
    int m_cnt  [3];
    int m_sym  [3][8];
    bit m_ov   [3];
    int m_word [3];
    int m_nsym [3];
    bit m_drop [3];

    function automatic int pack(input int i, input int fill);
        int w;
        int v;
        int pos;
        w = 0;
        for (int k = 0; k < pq_of(i); k++) begin
            v   = (k < fill) ? m_sym[i][k] : pad_of(i);
            v   = v & ((1 << sw_of(i)) - 1);
            pos = msb_of(i) ? (pq_of(i) - 1 - k) : k;
            w   = w | (v << (sw_of(i) * pos));
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_ov[i]   = 1'b0;
            m_word[i] = 0;
            m_nsym[i] = 0;
            m_drop[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit en, input int sym, input bit fl, input bit ordy);
        bit room;
        bit rdy;
        bit take;
        bit ftake;
        int fill;
        room  = !m_ov[i] || ordy;
        rdy   = (m_cnt[i] < pq_of(i) - 1) || room;
        take  = en && rdy;
        ftake = fl && room;
        fill  = m_cnt[i] + (take ? 1 : 0);
        m_drop[i] = en && !rdy;
        if (take) m_sym[i][fill-1] = sym;
        if (fill == pq_of(i) || (ftake && fill > 0)) begin
            m_word[i] = pack(i, fill);
            m_nsym[i] = fill;
            m_ov[i]   = 1'b1;
            m_cnt[i]  = 0;
        end else begin
            if (m_ov[i] && ordy) m_ov[i] = 1'b0;
            m_cnt[i] = fill;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, en_v[0], int'(sym_a), flush_v[0], ordy_v[0]);
            model_step(1, en_v[1], int'(sym_b), flush_v[1], ordy_v[1]);
            model_step(2, en_v[2], int'(sym_c), flush_v[2], ordy_v[2]);
        end
    end

    task automatic compare(input int i, input logic rdy, input logic ack, input logic valid,
                           input logic drop, input int word, input int nsym);
        bit room;
        room = !m_ov[i] || ordy_v[i];
        chk("o_rdy", i, int'(rdy), int'((m_cnt[i] < pq_of(i) - 1) || room));
        chk("o_flush_ack", i, int'(ack), int'(flush_v[i] && room));
        chk("o_valid", i, int'(valid), int'(m_ov[i]));
        chk("o_drop", i, int'(drop), int'(m_drop[i]));
        if (m_ov[i]) begin
            chk("o_all_symbols", i, word, m_word[i]);
            chk("o_nsym", i, nsym, m_nsym[i]);
        end
    endtask

    int hs_a[$];

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        compare(0, rdy_a, ack_a, valid_a, drop_a, int'(word_a), int'(nsym_a));
        compare(1, rdy_b, ack_b, valid_b, drop_b, int'(word_b), int'(nsym_b));
        compare(2, rdy_c, ack_c, valid_c, drop_c, int'(word_c), int'(nsym_c));
        if (!rst && valid_a && ordy_v[0]) hs_a.push_back(int'(word_a));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        int hs_base;
        bit ack_seen;

        rst   = 1'b1;
        sym_a = 4'h7;
        sym_b = 4'h0;
        sym_c = 3'h0;
        for (int i = 0; i < 3; i++) begin
            en_v[i]    = 1'b0;
            flush_v[i] = 1'b0;
            ordy_v[i]  = 1'b1;
        end
        en_v[0] = 1'b1;

        // Reset held with a symbol offered
        repeat (2) cyc();
        at_neg();
        chk("rst_valid", 0, int'(valid_a), 0);
        chk("rst_nsym", 0, int'(nsym_a), 0);
        chk("rst_word", 0, int'(word_a), 0);
        cyc();
        rst     = 1'b0;
        en_v[0] = 1'b0;
        repeat (2) cyc();
        at_neg();
        chk("idle_valid", 0, int'(valid_a), 0);
        chk("idle_rdy", 0, int'(rdy_a), 1);
        cyc();

        // Four symbols back-to-back, both packing orders
        for (int s = 1; s <= 4; s++) begin
            en_v[0] = 1'b1; en_v[1] = 1'b1;
            sym_a = 4'(s);  sym_b = 4'(s);
            cyc();
        end
        en_v[0] = 1'b0; en_v[1] = 1'b0;
        at_neg();
        chk("lsb_word", 0, int'(word_a), 'h4321);
        chk("lsb_nsym", 0, int'(nsym_a), 4);
        chk("lsb_valid", 0, int'(valid_a), 1);
        chk("msb_word", 1, int'(word_b), 'h1234);
        chk("msb_valid", 1, int'(valid_b), 1);
        cyc();

        // Partial flush with pad F, then flush on empty accumulator
        en_v[0] = 1'b1; sym_a = 4'hA; cyc();
        sym_a = 4'hB; cyc();
        en_v[0] = 1'b0; flush_v[0] = 1'b1;
        at_neg();
        chk("flush_ack", 0, int'(ack_a), 1);
        cyc();
        flush_v[0] = 1'b0;
        at_neg();
        chk("flush_word", 0, int'(word_a), 'hFFBA);
        chk("flush_nsym", 0, int'(nsym_a), 2);
        chk("flush_valid", 0, int'(valid_a), 1);
        chk("flush_ack_pulse", 0, int'(ack_a), 0);
        cyc();
        flush_v[0] = 1'b1;
        at_neg();
        chk("empty_flush_ack", 0, int'(ack_a), 1);
        cyc();
        flush_v[0] = 1'b0;
        at_neg();
        chk("empty_flush_noword", 0, int'(valid_a), 0);
        cyc();

        // Backpressure: word held, accumulator fills, extra symbol dropped
        hs_base   = hs_a.size();
        ordy_v[0] = 1'b0;
        for (int s = 1; s <= 7; s++) begin
            en_v[0] = 1'b1; sym_a = 4'(s);
            cyc();
        end
        sym_a = 4'h8;
        at_neg();
        chk("bp_rdy_low", 0, int'(rdy_a), 0);
        chk("bp_held_word", 0, int'(word_a), 'h4321);
        cyc();
        ordy_v[0] = 1'b1;
        at_neg();
        chk("bp_drop", 0, int'(drop_a), 1);
        chk("bp_rdy_release", 0, int'(rdy_a), 1);
        cyc();
        en_v[0] = 1'b0;
        at_neg();
        chk("bp_b2b_valid", 0, int'(valid_a), 1);
        chk("bp_b2b_word", 0, int'(word_a), 'h8765);
        cyc();
        at_neg();
        chk("bp_drain", 0, int'(valid_a), 0);
        chk("bp_hs_count", 0, hs_a.size() - hs_base, 2);
        if (hs_a.size() - hs_base == 2) begin
            chk("bp_hs_first", 0, hs_a[hs_base], 'h4321);
            chk("bp_hs_second", 0, hs_a[hs_base+1], 'h8765);
        end
        cyc();

        // Flush arriving with the fourth symbol gives exactly one full word
        for (int s = 1; s <= 3; s++) begin
            en_v[0] = 1'b1; sym_a = 4'(s);
            cyc();
        end
        sym_a = 4'h4; flush_v[0] = 1'b1;
        at_neg();
        chk("full_flush_ack", 0, int'(ack_a), 1);
        cyc();
        en_v[0] = 1'b0; flush_v[0] = 1'b0;
        at_neg();
        chk("full_flush_word", 0, int'(word_a), 'h4321);
        chk("full_flush_nsym", 0, int'(nsym_a), 4);
        cyc();
        at_neg();
        chk("full_flush_noextra", 0, int'(valid_a), 0);
        cyc();

        // MSB-first partial flush, pad 0
        en_v[1] = 1'b1; sym_b = 4'h1; cyc();
        sym_b = 4'h2; cyc();
        en_v[1] = 1'b0; flush_v[1] = 1'b1;
        at_neg();
        chk("msb_flush_ack", 1, int'(ack_b), 1);
        cyc();
        flush_v[1] = 1'b0;
        at_neg();
        chk("msb_flush_word", 1, int'(word_b), 'h1200);
        chk("msb_flush_nsym", 1, int'(nsym_b), 2);
        cyc();

        // 5x3 instance: reset mid-word discards the partial symbols
        en_v[2] = 1'b1; sym_c = 3'h7; cyc();
        sym_c = 3'h6; cyc();
        en_v[2] = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            en_v[2] = 1'b1; sym_c = 3'(s);
            cyc();
        end
        en_v[2] = 1'b0;
        at_neg();
        chk("rst_mid_word", 2, int'(word_c), 'h58D1);
        chk("rst_mid_nsym", 2, int'(nsym_c), 5);
        cyc();

        // Random traffic on the 5x3 instance with occasional resets
        ack_seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst       = ((n % 400) == 237);
            en_v[2]   = ($urandom_range(0, 3) != 0);
            sym_c     = 3'($urandom_range(0, 7));
            ordy_v[2] = ($urandom_range(0, 2) != 0);
            if (!(flush_v[2] && !ack_seen)) flush_v[2] = ($urandom_range(0, 9) == 0);
            at_neg();
            ack_seen = ack_c;
            cyc();
        end
        rst        = 1'b0;
        en_v[2]    = 1'b0;
        flush_v[2] = 1'b0;
        ordy_v[2]  = 1'b1;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
